// File: rtl/dcache_controller_if.sv
// Signal bundle joining dcache_controller to the MEM stage, the 2-way data cache and the SRAM.
// The master modport is the controller's view; slave is the view of everything around it.
interface dcache_controller_if #(
  parameter int ADDR_W = 32
) ();
  logic              mem_r_en;
  logic              mem_w_en;
  logic [ADDR_W-1:0] address;
  logic [ADDR_W-1:0] wdata;
  logic [ADDR_W-1:0] rdata;
  logic              ready;

  logic [18:0]       cache_address;
  logic              cache_read;
  logic              cache_write;
  logic              mem_write;
  logic [63:0]       cache_wdata;
  logic              cache_hit;
  logic [31:0]       cache_rdata;

  logic              sram_r_en;
  logic              sram_w_en;
  logic [ADDR_W-1:0] sram_address;
  logic [ADDR_W-1:0] sram_wdata;
  logic [63:0]       sram_rdata;
  logic              sram_ready;

  modport master (
    input  mem_r_en, mem_w_en, address, wdata, cache_hit, cache_rdata, sram_rdata, sram_ready,
    output rdata, ready, cache_address, cache_read, cache_write, mem_write, cache_wdata,
           sram_r_en, sram_w_en, sram_address, sram_wdata
  );

  modport slave (
    output mem_r_en, mem_w_en, address, wdata, cache_hit, cache_rdata, sram_rdata, sram_ready,
    input  rdata, ready, cache_address, cache_read, cache_write, mem_write, cache_wdata,
           sram_r_en, sram_w_en, sram_address, sram_wdata
  );
endinterface

// File: rtl/dcache_controller.sv
// Data-cache controller: 0-cycle read hits, SRAM line fill on miss, write-through stores.
// Optional hit/miss counters are compiled in when DCACHE_STATS_EN is defined.
module dcache_controller #(
  parameter int BASE_ADDR = 1024,
  parameter int ADDR_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  dcache_controller_if.master bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count
`endif
);

  typedef enum logic [1:0] {IDLE, MISS, FILL, WRITE} state_t;

  state_t            state_q, state_d;
  logic [63:0]       line_q, line_d;
  logic [ADDR_W-1:0] rdata_q, rdata_d;
  logic              sram_r_en_q, sram_r_en_d;
  logic              sram_w_en_q, sram_w_en_d;
  logic              cache_write_q, cache_write_d;
  logic              ready_c;

  logic              store_req;
  logic              load_req;
  logic              load_hit;
  logic              load_miss;
  logic [ADDR_W-1:0] fill_word;

  // A store wins when both enables are high, so a load is only seen without mem_w_en.
  assign store_req = (state_q == IDLE) && bus.mem_w_en;
  assign load_req  = (state_q == IDLE) && bus.mem_r_en && !bus.mem_w_en;
  assign load_hit  = load_req && bus.cache_hit;
  assign load_miss = load_req && !bus.cache_hit;
  assign fill_word = ADDR_W'(bus.address[2] ? line_q[63:32] : line_q[31:0]);

  assign bus.cache_address = 19'(bus.address - ADDR_W'(BASE_ADDR));
  assign bus.sram_address  = bus.address;
  assign bus.sram_wdata    = bus.wdata;
  assign bus.cache_read    = load_req;
  assign bus.mem_write     = store_req;
  assign bus.cache_write   = cache_write_q;
  assign bus.cache_wdata   = line_q;
  assign bus.sram_r_en     = sram_r_en_q;
  assign bus.sram_w_en     = sram_w_en_q;
  assign bus.ready         = ready_c;
  assign bus.rdata         = rdata_d;

  always_comb begin
    ready_c = 1'b1;
    unique case (state_q)
      IDLE:    ready_c = !(store_req || load_miss);
      MISS:    ready_c = 1'b0;
      FILL:    ready_c = 1'b1;
      WRITE:   ready_c = bus.sram_ready;
      default: ready_c = 1'b1;
    endcase
  end

  // Load data is live on hit and fill cycles, otherwise the last delivered word is held.
  always_comb begin
    rdata_d = rdata_q;
    if (load_hit) begin
      rdata_d = ADDR_W'(bus.cache_rdata);
    end else if (state_q == FILL) begin
      rdata_d = fill_word;
    end
  end

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    unique case (state_q)
      IDLE: begin
        if (bus.mem_w_en) begin
          state_d = WRITE;
        end else if (load_miss) begin
          state_d = MISS;
        end
      end
      MISS: begin
        if (bus.sram_ready) begin
          line_d  = bus.sram_rdata;
          state_d = FILL;
        end
      end
      FILL: state_d = IDLE;
      WRITE: begin
        if (bus.sram_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Strobes are registered copies of the next state so reset clears them asynchronously.
    sram_r_en_d   = (state_d == MISS);
    sram_w_en_d   = (state_d == WRITE);
    cache_write_d = (state_d == FILL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      rdata_q       <= '0;
      sram_r_en_q   <= 1'b0;
      sram_w_en_q   <= 1'b0;
      cache_write_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rdata_q       <= rdata_d;
      sram_r_en_q   <= sram_r_en_d;
      sram_w_en_q   <= sram_w_en_d;
      cache_write_q <= cache_write_d;
    end
  end

  // The line buffer is pure data and is only meaningful after an SRAM ack.
  always_ff @(posedge clk) begin
    line_q <= line_d;
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (load_hit && (hit_count_q != '1)) begin
      hit_count_d = hit_count_q + 32'd1;
    end
    if (load_miss && (miss_count_q != '1)) begin
      miss_count_d = miss_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: directed vector table, reset corner cases,
// and randomized transactions checked against a transaction-level model of the controller.
module tb_dcache_controller;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcache_controller_if #(.ADDR_W(32)) bus ();

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  dcache_controller #(.BASE_ADDR(1024), .ADDR_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count(hit_count),
    .miss_count(miss_count)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  int m_hits = 0;
  int m_misses = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_strobes(input string tag, input logic rdy, input logic cr, input logic cw,
                             input logic mw, input logic sr, input logic sw);
    chk({tag, ".ready"}, 64'(bus.ready), 64'(rdy));
    chk({tag, ".cache_read"}, 64'(bus.cache_read), 64'(cr));
    chk({tag, ".cache_write"}, 64'(bus.cache_write), 64'(cw));
    chk({tag, ".mem_write"}, 64'(bus.mem_write), 64'(mw));
    chk({tag, ".sram_r_en"}, 64'(bus.sram_r_en), 64'(sr));
    chk({tag, ".sram_w_en"}, 64'(bus.sram_w_en), 64'(sw));
  endtask

  // One complete MEM-stage request, cycle by cycle. Called right after a rising edge.
  task automatic run_txn(input string tag, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] wd, input logic hit,
                         input logic [31:0] crd, input int lat, input logic [63:0] line,
                         input logic [18:0] exp_ca, input logic [31:0] exp_rd);
    bus.mem_r_en = r;
    bus.mem_w_en = w;
    bus.address = a;
    bus.wdata = wd;
    bus.cache_hit = hit;
    bus.cache_rdata = crd;
    bus.sram_ready = 1'b0;
    bus.sram_rdata = {$urandom, $urandom};
    @(negedge clk);
    chk({tag, ".cache_address"}, 64'(bus.cache_address), 64'(exp_ca));
    chk({tag, ".sram_address"}, 64'(bus.sram_address), 64'(a));
    chk({tag, ".sram_wdata"}, 64'(bus.sram_wdata), 64'(wd));
    if (w) begin
      chk_strobes({tag, ".req"}, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    end else if (hit) begin
      chk_strobes({tag, ".req"}, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk({tag, ".hit_rdata"}, 64'(bus.rdata), 64'(exp_rd));
      m_hits++;
    end else begin
      chk_strobes({tag, ".req"}, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      m_misses++;
    end
    @(posedge clk);
    #1;
    if (w || !hit) begin
      for (int i = 1; i <= lat; i++) begin
        bus.sram_ready = (i == lat);
        bus.sram_rdata = (i == lat) ? line : {$urandom, $urandom};
        bus.cache_hit = 1'($urandom);
        bus.cache_rdata = $urandom;
        @(negedge clk);
        chk_strobes({tag, ".wait"}, w && (i == lat), 1'b0, 1'b0, 1'b0, !w, w);
        @(posedge clk);
        #1;
      end
      if (!w) begin
        bus.sram_ready = 1'($urandom);
        bus.sram_rdata = {$urandom, $urandom};
        @(negedge clk);
        chk_strobes({tag, ".fill"}, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk({tag, ".fill_line"}, bus.cache_wdata, line);
        chk({tag, ".fill_rdata"}, 64'(bus.rdata), 64'(exp_rd));
        @(posedge clk);
        #1;
      end
    end
    bus.mem_r_en = 1'b0;
    bus.mem_w_en = 1'b0;
    bus.sram_ready = 1'($urandom);
    @(negedge clk);
    chk_strobes({tag, ".idle"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    bus.sram_ready = 1'b0;
  endtask

  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        hit;
    logic [31:0] crd;
    int          lat;
    logic [63:0] line;
    logic [18:0] exp_ca;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'h0000_0408, 32'h0, 1'b1, 32'hDEADBEEF, 1, 64'h0, 19'h00008, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_040C, 32'h0, 1'b0, 32'h0, 3, 64'h11112222_33334444, 19'h0000C, 32'h11112222};
    vecs[2] = '{1'b0, 1'b1, 32'h0000_0500, 32'h55, 1'b0, 32'h0, 2, 64'h0, 19'h00100, 32'h0};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_0408, 32'hA5, 1'b1, 32'h77, 1, 64'h0, 19'h00008, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0408, 32'h0, 1'b0, 32'h0, 1, 64'hCAFEF00D_12345678, 19'h00008, 32'h12345678};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0, 1'b1, 32'h0BADC0DE, 1, 64'h0, 19'h7FC04, 32'h0BADC0DE};
    vecs[6] = '{1'b1, 1'b0, 32'h0007_FFFC, 32'h0, 1'b0, 32'h0, 4, 64'h89ABCDEF_01234567, 19'h7FBFC, 32'h89ABCDEF};
    vecs[7] = '{1'b0, 1'b1, 32'h1000_0404, 32'h12345678, 1'b1, 32'h0, 1, 64'h0, 19'h00004, 32'h0};

    rst = 1'b0;
    bus.mem_r_en = 1'b0;
    bus.mem_w_en = 1'b0;
    bus.address = 32'h400;
    bus.wdata = 32'h0;
    bus.cache_hit = 1'b0;
    bus.cache_rdata = 32'h0;
    bus.sram_rdata = 64'h0;
    bus.sram_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_strobes("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.rdata", 64'(bus.rdata), 64'h0);
`ifdef DCACHE_STATS_EN
    chk("reset.hit_count", 64'(hit_count), 64'h0);
    chk("reset.miss_count", 64'(miss_count), 64'h0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].r, vecs[i].w, vecs[i].addr, vecs[i].wd, vecs[i].hit,
              vecs[i].crd, vecs[i].lat, vecs[i].line, vecs[i].exp_ca, vecs[i].exp_rd);
    end

    // Reset pulled low while a miss is waiting on SRAM: the request must be abandoned.
    bus.mem_r_en = 1'b1;
    bus.address = 32'h0000_0410;
    bus.cache_hit = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rstmiss.sram_r_en_before", 64'(bus.sram_r_en), 64'h1);
    #2;
    rst = 1'b0;
    bus.mem_r_en = 1'b0;
    #1;
    chk("rstmiss.sram_r_en_async", 64'(bus.sram_r_en), 64'h0);
    chk("rstmiss.ready", 64'(bus.ready), 64'h1);
    m_hits = 0;
    m_misses = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.sram_ready = 1'b1;
    bus.sram_rdata = 64'hFFFF0000_FFFF0000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk_strobes($sformatf("rstmiss.after%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      bus.sram_ready = 1'b0;
    end

    run_txn("stats.hit0", 1'b1, 1'b0, 32'h420, 32'h0, 1'b1, 32'h1, 1, 64'h0, 19'h00020, 32'h1);
    run_txn("stats.hit1", 1'b1, 1'b0, 32'h424, 32'h0, 1'b1, 32'h2, 1, 64'h0, 19'h00024, 32'h2);
    run_txn("stats.miss", 1'b1, 1'b0, 32'h428, 32'h0, 1'b0, 32'h0, 2, 64'h5555AAAA_0F0F0F0F,
            19'h00028, 32'h0F0F0F0F);
`ifdef DCACHE_STATS_EN
    chk("stats.hit_count", 64'(hit_count), 64'd2);
    chk("stats.miss_count", 64'(miss_count), 64'd1);
`endif

    for (int n = 0; n < 200; n++) begin
      int          kind;
      logic        r, w, hit;
      logic [31:0] a, wd, crd, exp_rd;
      logic [63:0] line;
      int          lat;
      kind = $urandom_range(0, 3);
      w = (kind <= 1);
      r = (kind >= 1);
      hit = (kind == 2) ? 1'b1 : (kind == 3) ? 1'b0 : 1'($urandom);
      if ($urandom_range(0, 3) == 0) a = {$urandom} & 32'hFFFF_FFFC;
      else a = 32'h400 + (32'($urandom_range(0, 16383)) << 2);
      wd = $urandom;
      crd = $urandom;
      line = {$urandom, $urandom};
      lat = $urandom_range(1, 5);
      if (!w && hit) exp_rd = crd;
      else if (!w) exp_rd = a[2] ? line[63:32] : line[31:0];
      else exp_rd = 32'h0;
      run_txn($sformatf("rnd%0d", n), r, w, a, wd, hit, crd, lat, line,
              19'((a - 32'd1024) % 32'h80000), exp_rd);
    end
`ifdef DCACHE_STATS_EN
    chk("final.hit_count", 64'(hit_count), 64'(m_hits));
    chk("final.miss_count", 64'(miss_count), 64'(m_misses));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
